data_mem_resp: RTL



---
 rtl/data_mem_resp.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/data_mem_resp.sv
// Purpose : load/store responder for the execute stage; owns the word-organised data RAM.
// Latency : stores commit at the request edge; load data appears on regOp two cycles after the request.
// Backpr. : none - one request accepted every cycle, never stalls; regOp.dv is a one-cycle pulse.
//
// Ports   : clk, rst (sync, active-high) | memOp  - request from ALU (read/write/addr/data/opType/rdAddr)
//           flush  - drops the current request and the stage-1 load
//           regOp  - load writeback | loadPend - stage-1 load destination (hazard detect)
//           memErr - one-cycle pulse the cycle after an illegal request
// Config  : `define DATA_MEM_MISALIGN_CHK_EN to reject misaligned accesses; otherwise the
//           offset is forced to the natural alignment of the access size.

package corePckg;
  localparam int cXLEN     = 32;
  localparam int cRamDepth = 1024;

  typedef struct packed {
    logic             read;
    logic             write;
    logic [cXLEN-1:0] addr;
    logic [cXLEN-1:0] data;
    logic [2:0]       opType;
    logic [4:0]       rdAddr;
  } tMemOp;

  typedef struct packed {
    logic             dv;
    logic [4:0]       addr;
    logic [cXLEN-1:0] data;
  } tRegOp;

  localparam tRegOp cRegOp = '0;
endpackage

module data_mem_resp
  import corePckg::*;
#(
  parameter int pDepth = cRamDepth,
  parameter int pXlen  = cXLEN
) (
  input  logic  clk,
  input  logic  rst,
  input  tMemOp memOp,
  input  logic  flush,
  output tRegOp regOp,
  output tRegOp loadPend,
  output logic  memErr
);

  localparam int cAw = $clog2(pDepth);

  logic [pXlen-1:0] ram [pDepth];
  logic [pXlen-1:0] rdWord;

  logic [cAw-1:0]   wordIdx;
  logic [1:0]       offset;
  logic             isLoad, isStore, badReq, misErr;
  logic             doRead, doWrite, errNxt;
  logic [3:0]       byteEn;
  logic [pXlen-1:0] wrData;

  logic             s1Vld;
  logic [2:0]       s1Op;
  logic [1:0]       s1Off;
  logic [4:0]       s1Rd;
  logic [7:0]       ldByte;
  logic [15:0]      ldHalf;
  logic [cXLEN-1:0] ldData;

  // Address bits above the RAM are deliberately ignored (accesses wrap).
  logic unusedAddrBits;
  assign unusedAddrBits = &{1'b0, memOp.addr[cXLEN-1:cAw+2]};

  assign wordIdx = memOp.addr[cAw+1:2];

  // Request decode
  always_comb begin
    isLoad  = memOp.read & ~memOp.write;
    isStore = memOp.write & ~memOp.read;
    misErr  = 1'b0;
    offset  = memOp.addr[1:0];
`ifdef DATA_MEM_MISALIGN_CHK_EN
    misErr = (memOp.opType[1:0] == 2'b01 && memOp.addr[0]) ||
             (memOp.opType[1:0] == 2'b10 && memOp.addr[1:0] != 2'b00);
`else
    // Snap the offset to the natural alignment of the access size.
    if (memOp.opType[1:0] == 2'b01) offset = {memOp.addr[1], 1'b0};
    else if (memOp.opType[1:0] == 2'b10) offset = 2'b00;
`endif
    // Loads: LB LH LW LBU LHU. Stores: SB SH SW.
    badReq = (memOp.read & memOp.write) |
             (isLoad  & (memOp.opType == 3'b011 || memOp.opType[2:1] == 2'b11)) |
             (isStore & (memOp.opType[2] || memOp.opType[1:0] == 2'b11)) |
             misErr;
    errNxt  = (memOp.read | memOp.write) & ~flush & badReq;
    doRead  = isLoad  & ~flush & ~badReq;
    doWrite = isStore & ~flush & ~badReq;

    // Data is replicated across lanes so the byte enables alone pick the target lanes.
    case (memOp.opType[1:0])
      2'b00: begin
        byteEn = 4'b0001 << offset;
        wrData = {4{memOp.data[7:0]}};
      end
      2'b01: begin
        byteEn = 4'b0011 << offset;
        wrData = {2{memOp.data[15:0]}};
      end
      default: begin
        byteEn = 4'b1111;
        wrData = memOp.data;
      end
    endcase
  end

  // Data RAM: byte-lane write and registered read; contents are never reset.
  always_ff @(posedge clk) begin
    if (doWrite) begin
      for (int i = 0; i < 4; i++) begin
        if (byteEn[i]) ram[wordIdx][i*8 +: 8] <= wrData[i*8 +: 8];
      end
    end
    if (doRead) rdWord <= ram[wordIdx];
  end

  // Lane select and sign/zero extension from the stage-1 attributes.
  always_comb begin
    case (s1Off)
      2'd0:    ldByte = rdWord[7:0];
      2'd1:    ldByte = rdWord[15:8];
      2'd2:    ldByte = rdWord[23:16];
      default: ldByte = rdWord[31:24];
    endcase
    ldHalf = s1Off[1] ? rdWord[31:16] : rdWord[15:0];
    case (s1Op)
      3'b000:  ldData = {{24{ldByte[7]}}, ldByte};
      3'b001:  ldData = {{16{ldHalf[15]}}, ldHalf};
      3'b100:  ldData = {24'd0, ldByte};
      3'b101:  ldData = {16'd0, ldHalf};
      default: ldData = rdWord;
    endcase
  end

  // Stage 1 and writeback registers
  always_ff @(posedge clk) begin
    if (rst) begin
      s1Vld  <= 1'b0;
      s1Op   <= '0;
      s1Off  <= '0;
      s1Rd   <= '0;
      regOp  <= cRegOp;
      memErr <= 1'b0;
    end else begin
      // A load to x0 still reads the RAM but never becomes a pending writeback.
      s1Vld  <= doRead && (memOp.rdAddr != 5'd0);
      s1Op   <= memOp.opType;
      s1Off  <= offset;
      s1Rd   <= memOp.rdAddr;
      memErr <= errNxt;
      if (s1Vld && !flush) begin
        regOp.dv   <= 1'b1;
        regOp.addr <= s1Rd;
        regOp.data <= ldData;
      end else begin
        regOp.dv <= 1'b0;
      end
    end
  end

  always_comb begin
    loadPend      = cRegOp;
    loadPend.dv   = s1Vld;
    loadPend.addr = s1Rd;
  end

endmodule
